bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter.sv | 138 +++++++++++++
 tb/tb_bram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester round-robin arbiter in front of a single
// write port / single read port RAM, with a zero-fill sweep after reset
// or on request.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   init_req_i / busy_o     request a zero-fill sweep / sweep in progress
//   wr_req_i, wr_addr*_i,   per-requester write requests, addresses, data
//   wr_data*_i, wr_gnt_o    and one-hot-or-zero combinational write grant
//   rd_req_i, rd_addr*_i,   per-requester read requests, addresses,
//   rd_gnt_o                one-hot-or-zero combinational read grant
//   rd_valid_o, rd_data_o   read data valid (tagged by requester), data
//   we_o, waddr_o, din_o    RAM write port
//   raddr_o, dout_i         RAM read port (registered read, 1-cycle latency)
module bram_arbiter #(
    parameter int AW = 3,
    parameter int DW = 6
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          init_req_i,
    output logic          busy_o,
    input  logic [1:0]    wr_req_i,
    input  logic [AW-1:0] wr_addr0_i,
    input  logic [AW-1:0] wr_addr1_i,
    input  logic [DW-1:0] wr_data0_i,
    input  logic [DW-1:0] wr_data1_i,
    output logic [1:0]    wr_gnt_o,
    input  logic [1:0]    rd_req_i,
    input  logic [AW-1:0] rd_addr0_i,
    input  logic [AW-1:0] rd_addr1_i,
    output logic [1:0]    rd_gnt_o,
    output logic [1:0]    rd_valid_o,
    output logic [DW-1:0] rd_data_o,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [DW-1:0] din_o,
    output logic [AW-1:0] raddr_o,
    input  logic [DW-1:0] dout_i
);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wprio_q, wprio_d;   // requester that wins a tie
    logic          rprio_q, rprio_d;
    logic [1:0]    rd_valid_q;
    logic          we_c;

    // Round-robin pick among two requesters; prio selects the tie winner.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
        logic [1:0] g;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = prio ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            wprio_q    <= 1'b0;
            rprio_q    <= 1'b0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wprio_q    <= wprio_d;
            rprio_q    <= rprio_d;
            rd_valid_q <= rd_gnt_o;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wprio_d  = wprio_q;
        rprio_d  = rprio_q;
        busy_o   = 1'b0;
        wr_gnt_o = '0;
        rd_gnt_o = '0;
        we_c     = 1'b0;
        waddr_o  = '0;
        din_o    = '0;
        raddr_o  = '0;

        case (state_q)
            INIT: begin
                busy_o  = 1'b1;
                we_c    = 1'b1;
                waddr_o = cnt_q;
                // Counter wraps back to 0 on the last address, ready for RUN.
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = RUN;
            end
            default: begin
                wr_gnt_o = rr_pick(wr_req_i, wprio_q);
                rd_gnt_o = rr_pick(rd_req_i, rprio_q);

                we_c = |wr_gnt_o;
                if (wr_gnt_o[0]) begin
                    waddr_o = wr_addr0_i;
                    din_o   = wr_data0_i;
                    wprio_d = 1'b1;
                end else if (wr_gnt_o[1]) begin
                    waddr_o = wr_addr1_i;
                    din_o   = wr_data1_i;
                    wprio_d = 1'b0;
                end

                if (rd_gnt_o[0]) begin
                    raddr_o = rd_addr0_i;
                    rprio_d = 1'b1;
                end else if (rd_gnt_o[1]) begin
                    raddr_o = rd_addr1_i;
                    rprio_d = 1'b0;
                end

                // Grants of this cycle still complete; the sweep starts next edge.
                if (init_req_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Reset must block RAM writes even though INIT normally drives we=1.
    assign we_o       = we_c & rst_n_i;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = dout_i;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: randomized and directed stimulus for bram_arbiter with a
// behavioural RAM and a cycle-level reference model of the arbitration rules.
module tb_bram_arbiter;
    localparam int AW    = 3;
    localparam int DW    = 6;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n, init_req, busy, we;
    logic [1:0]    wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
    logic [AW-1:0] wr_addr0, wr_addr1, rd_addr0, rd_addr1, waddr, raddr;
    logic [DW-1:0] wr_data0, wr_data1, din, dout, rd_data;

    always #5 clk = ~clk;

    bram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .init_req_i(init_req), .busy_o(busy),
        .wr_req_i(wr_req), .wr_addr0_i(wr_addr0), .wr_addr1_i(wr_addr1),
        .wr_data0_i(wr_data0), .wr_data1_i(wr_data1), .wr_gnt_o(wr_gnt),
        .rd_req_i(rd_req), .rd_addr0_i(rd_addr0), .rd_addr1_i(rd_addr1),
        .rd_gnt_o(rd_gnt), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .we_o(we), .waddr_o(waddr), .din_o(din), .raddr_o(raddr), .dout_i(dout)
    );

    // Write-first RAM with registered read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (we) ram[waddr] <= din;
        dout <= (we && waddr == raddr) ? din : ram[raddr];
    end

    // Reference model state.
    int            sweep_left;        // >0: sweep in progress, next addr = DEPTH-sweep_left
    int            wfav, rfav;        // requester index that wins a tie
    logic [1:0]    m_valid;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_mem [DEPTH];

    int nchecks = 0;
    int nerrs   = 0;

    // Stimulus for the next cycle.
    logic          s_rst, s_ir;
    logic [1:0]    s_wq, s_rq;
    logic [AW-1:0] s_wa0, s_wa1, s_ra0, s_ra1;
    logic [DW-1:0] s_wd0, s_wd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] req, input int fav);
        if (req == 2'b11) return fav;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int idx);
        return (idx < 0) ? 2'b00 : 2'(1 << idx);
    endfunction

    task automatic do_cycle();
        int ww, rw;
        logic [AW-1:0] ewa, era;
        logic [DW-1:0] ewd;
        ww = -1; rw = -1; ewa = '0; era = '0; ewd = '0;
        @(negedge clk);
        rst_n = s_rst; init_req = s_ir;
        wr_req = s_wq; wr_addr0 = s_wa0; wr_addr1 = s_wa1; wr_data0 = s_wd0; wr_data1 = s_wd1;
        rd_req = s_rq; rd_addr0 = s_ra0; rd_addr1 = s_ra1;
        if (!s_rst) begin
            sweep_left = DEPTH; wfav = 0; rfav = 0; m_valid = '0;
        end
        #1;
        if (!s_rst) begin
            chk("rst_busy", busy, 1);
            chk("rst_wgnt", wr_gnt, 0);
            chk("rst_rgnt", rd_gnt, 0);
            chk("rst_we", we, 0);
        end else if (sweep_left > 0) begin
            chk("init_busy", busy, 1);
            chk("init_wgnt", wr_gnt, 0);
            chk("init_rgnt", rd_gnt, 0);
            chk("init_we", we, 1);
            chk("init_waddr", waddr, DEPTH - sweep_left);
            chk("init_din", din, 0);
            chk("init_raddr", raddr, 0);
        end else begin
            ww = pick(s_wq, wfav);
            rw = pick(s_rq, rfav);
            if (ww == 0) begin ewa = s_wa0; ewd = s_wd0; end
            if (ww == 1) begin ewa = s_wa1; ewd = s_wd1; end
            if (rw == 0) era = s_ra0;
            if (rw == 1) era = s_ra1;
            chk("run_busy", busy, 0);
            chk("wgnt", wr_gnt, onehot(ww));
            chk("rgnt", rd_gnt, onehot(rw));
            chk("we", we, (ww >= 0) ? 1 : 0);
            chk("waddr", waddr, ewa);
            chk("din", din, ewd);
            chk("raddr", raddr, era);
        end
        chk("rd_valid", rd_valid, m_valid);
        if (m_valid != 0) chk("rd_data", rd_data, m_data);
        @(posedge clk);
        if (s_rst) begin
            if (sweep_left > 0) begin
                m_mem[DEPTH - sweep_left] = '0;
                sweep_left--;
                m_valid = '0;
            end else begin
                if (ww >= 0) begin
                    m_mem[ewa] = ewd;
                    wfav = 1 - ww;
                end
                if (rw >= 0) begin
                    rfav    = 1 - rw;
                    m_data  = m_mem[era];
                    m_valid = onehot(rw);
                end else begin
                    m_valid = '0;
                end
                if (s_ir) sweep_left = DEPTH;
            end
        end
    endtask

    task automatic idle();
        s_rst = 1'b1; s_ir = 1'b0; s_wq = '0; s_rq = '0;
        s_wa0 = '0; s_wa1 = '0; s_wd0 = '0; s_wd1 = '0; s_ra0 = '0; s_ra1 = '0;
    endtask

    task automatic randomize_reqs();
        s_wq  = 2'($urandom_range(0, 3)); s_rq  = 2'($urandom_range(0, 3));
        s_wa0 = AW'($urandom); s_wa1 = AW'($urandom);
        s_ra0 = AW'($urandom); s_ra1 = AW'($urandom);
        s_wd0 = DW'($urandom); s_wd1 = DW'($urandom);
    endtask

    initial begin
        sweep_left = DEPTH; wfav = 0; rfav = 0; m_valid = '0; m_data = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        rst_n = 1'b0; init_req = 1'b0; wr_req = '0; rd_req = '0;
        wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        rd_addr0 = '0; rd_addr1 = '0;

        // Held reset, then the initial sweep with requests/init_req that must be ignored.
        idle(); s_rst = 1'b0;
        for (int i = 0; i < 3; i++) do_cycle();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); randomize_reqs(); s_ir = (i == 3);
            do_cycle();
        end
        idle(); do_cycle();

        // Both writers held four cycles: alternate grants starting with requester 0.
        for (int i = 0; i < 4; i++) begin
            idle(); s_wq = 2'b11; s_wa0 = 3'd1; s_wa1 = 3'd2; s_wd0 = 6'd5; s_wd1 = 6'd6;
            do_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            idle(); s_rq = 2'b11; s_ra0 = 3'd1; s_ra1 = 3'd2;
            do_cycle();
        end
        idle(); do_cycle();

        // Single read of stored data.
        idle(); s_wq = 2'b01; s_wa0 = 3'd3; s_wd0 = 6'd7; do_cycle();
        idle(); s_rq = 2'b01; s_ra0 = 3'd3; do_cycle();
        idle(); do_cycle();

        // Write and read of the same address in one cycle.
        idle(); s_wq = 2'b10; s_wa1 = 3'd4; s_wd1 = 6'd3; s_rq = 2'b01; s_ra0 = 3'd4; do_cycle();
        idle(); do_cycle();

        // Init request alongside a read; the read still completes.
        idle(); s_ir = 1'b1; s_rq = 2'b10; s_ra1 = 3'd2; do_cycle();
        for (int i = 0; i < DEPTH + 1; i++) begin idle(); do_cycle(); end

        // Reset asserted mid-sweep at cycle 5, then a full sweep from address 0.
        idle(); s_ir = 1'b1; do_cycle();
        for (int i = 0; i < 5; i++) begin idle(); do_cycle(); end
        idle(); s_rst = 1'b0; do_cycle();
        for (int i = 0; i < DEPTH + 2; i++) begin idle(); do_cycle(); end

        // Randomized traffic with occasional init requests and resets.
        for (int i = 0; i < 800; i++) begin
            idle(); randomize_reqs();
            s_ir  = ($urandom_range(0, 49) == 0);
            s_rst = ($urandom_range(0, 199) != 0);
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
        $finish;
    end
endmodule
